// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, variable-latency memory between the core's
// instruction-fetch port and its data (load/store) port. One access is in
// flight at a time. Data wins contention, but after STARVE_LIMIT data grants
// that were each taken while fetch was also waiting, fetch is forced through.
// An access that sees no mem_ack within TIMEOUT busy cycles is aborted: the
// requester gets its ready pulse with zero read data, and bus_err/err_src
// report the abort for one cycle.
//
// Parameters
//   STARVE_LIMIT  consecutive contended data grants before fetch is forced
//   TIMEOUT       busy cycles without mem_ack before abort (0 = never)
//   CNT_W         timeout counter width, 2**CNT_W > TIMEOUT
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   if_req/if_addr                 fetch request (held until if_ready)
//   if_rdata/if_ready              fetched word, one-cycle completion pulse
//   d_req/d_wr/d_addr/d_wdata      data request (held until d_ready)
//   d_rdata/d_ready                load data, one-cycle completion pulse
//   mem_req/mem_wr/mem_addr/
//   mem_wdata                      memory request, stable while busy
//   mem_rdata/mem_ack              memory response
//   stall                          pipeline freeze while any port waits
//   bus_err/err_src                timeout pulse, 0 = fetch, 1 = data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,

  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,

  output logic        stall,
  output logic        bus_err,
  output logic        err_src
);

  // Starvation counter only needs to reach STARVE_LIMIT.
  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = STARVE_LIMIT[SC_W-1:0];

  // The counter holds the number of busy cycles already spent without ack,
  // so expiry is detected in the TIMEOUT-th busy cycle (count TIMEOUT-1).
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam int TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [SC_W-1:0]   starve_q,    starve_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_wr_q,    mem_wr_d;
  logic [31:0]       mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q,  if_rdata_d;
  logic [31:0]       d_rdata_q,   d_rdata_d;
  logic              if_ready_q,  if_ready_d;
  logic              d_ready_q,   d_ready_d;
  logic              bus_err_q,   bus_err_d;
  logic              err_src_q,   err_src_d;

  logic              if_elig;
  logic              d_elig;
  logic              busy_d_src;

  // A requester whose ready pulse is visible this cycle is still holding req
  // for the access that just finished, so it must not be re-granted yet.
  assign if_elig    = if_req & ~if_ready_q;
  assign d_elig     = d_req  & ~d_ready_q;
  assign busy_d_src = (state_q == BUSY_D);

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;
    err_src_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Data wins unless fetch is also waiting and has been passed over
        // STARVE_LIMIT times in a row.
        if (d_elig && (!if_elig || (starve_q < STARVE_MAX))) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_wr_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (if_elig) begin
            starve_d = starve_q + SC_W'(1);
          end
        end else if (if_elig) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          // Ack takes precedence over a simultaneous timeout expiry.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (busy_d_src) begin
            d_ready_d = 1'b1;
            if (!mem_wr_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Abort: complete the requester with zero data and flag it.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          bus_err_d = 1'b1;
          err_src_d = busy_d_src;
          if (busy_d_src) begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = '0;
          end
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      err_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
      err_src_q   <= err_src_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign bus_err   = bus_err_q;
  assign err_src   = err_src_q;

  // Freeze the pipeline while either port has an outstanding request.
  assign stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios (single fetch, store with wait states, load timeout,
// ack/timeout collision, reset mid-access, continuous contention, fetch
// starvation) followed by randomized traffic. A transaction-level reference
// model tracks the one outstanding access, its latched request, the busy
// cycle count and the starvation count, and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int SL = 4;
  localparam int TO = 5;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        bus_err;
  logic        err_src;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT(SL),
    .TIMEOUT     (TO),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_req  (mem_req),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall    (stall),
    .bus_err  (bus_err),
    .err_src  (err_src)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the access in flight and the visible completion state.
  logic        m_busy;
  logic        m_src;      // 0 = fetch, 1 = data
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_cnt;      // busy cycles already spent without ack
  int          m_starve;
  logic        m_if_ready;
  logic        m_d_ready;
  logic [31:0] m_if_rdata;
  logic [31:0] m_d_rdata;
  logic        m_bus_err;
  logic        m_err_src;

  int          cur_lat;    // ack arrives in busy cycle cur_lat+1
  int          force_lat = -1;
  int          mode = 3;   // 0 random, 1 starve, 2 held, 3 directed
  logic        fix_rd = 1'b0;
  logic [31:0] fix_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_src = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    m_cnt = 0; m_starve = 0;
    m_if_ready = 0; m_d_ready = 0; m_if_rdata = '0; m_d_rdata = '0;
    m_bus_err = 0; m_err_src = 0; cur_lat = 0;
  endtask

  function automatic int pick_lat();
    int r;
    if (force_lat >= 0) return force_lat;
    r = int'($urandom_range(0, 9));
    if (r < 6) return r % 4;
    return r - 2;            // 4 (collision) .. 7 (timeouts)
  endfunction

  task automatic check_outputs();
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) begin
      chk("mem_wr", 32'(mem_wr), 32'(m_wr));
      chk("mem_addr", mem_addr, m_addr);
      if (m_src) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_ready", 32'(if_ready), 32'(m_if_ready));
    chk("d_ready", 32'(d_ready), 32'(m_d_ready));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("bus_err", 32'(bus_err), 32'(m_bus_err));
    chk("err_src", 32'(err_src), 32'(m_err_src));
  endtask

  task automatic drive_inputs();
    case (mode)
      0: begin
        if (m_if_ready) if_req = 1'($urandom_range(0, 1));
        else if (if_req) if_req = ($urandom_range(0, 15) != 0);
        else if_req = ($urandom_range(0, 2) == 0);
        if (m_d_ready) d_req = 1'($urandom_range(0, 1));
        else if (d_req) d_req = ($urandom_range(0, 15) != 0);
        else d_req = ($urandom_range(0, 2) == 0);
        if_addr = $urandom;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wr    = 1'($urandom_range(0, 1));
      end
      1: begin
        d_req  = 1'b1;
        if_req = ~m_d_ready;
        d_wr   = 1'b0;
      end
      2: begin
        d_req  = 1'b1;
        if_req = 1'b1;
      end
      default: begin
        if (m_if_ready) if_req = 1'b0;
        if (m_d_ready) d_req = 1'b0;
      end
    endcase
    if (m_busy) mem_ack = (m_cnt == cur_lat);
    else mem_ack = ($urandom_range(0, 7) == 0);
    mem_rdata = fix_rd ? fix_rdata : $urandom;
  endtask

  task automatic grant(input logic src);
    m_busy  = 1; m_src = src; m_cnt = 0;
    m_wr    = src ? d_wr : 1'b0;
    m_addr  = src ? d_addr : if_addr;
    m_wdata = d_wdata;
    cur_lat = pick_lat();
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic ie, de, nir, ndr, nbe, nes;
    ie = if_req & ~m_if_ready;
    de = d_req & ~m_d_ready;
    nir = 0; ndr = 0; nbe = 0; nes = 0;
    if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0;
        if (m_src) begin
          ndr = 1;
          if (!m_wr) m_d_rdata = mem_rdata;
        end else begin
          nir = 1;
          m_if_rdata = mem_rdata;
        end
      end else if (m_cnt + 1 == TO) begin
        m_busy = 0; nbe = 1; nes = m_src;
        if (m_src) begin ndr = 1; m_d_rdata = '0; end
        else begin nir = 1; m_if_rdata = '0; end
      end else begin
        m_cnt++;
      end
    end else if (de && ie) begin
      if (m_starve < SL) begin grant(1'b1); m_starve++; end
      else begin grant(1'b0); m_starve = 0; end
    end else if (ie) begin
      grant(1'b0); m_starve = 0;
    end else if (de) begin
      grant(1'b1);
    end
    m_if_ready = nir; m_d_ready = ndr; m_bus_err = nbe; m_err_src = nes;
  endtask

  task automatic cycle();
    check_outputs();
    drive_inputs();
    #1;
    chk("stall", 32'(stall), 32'((if_req & ~m_if_ready) | (d_req & ~m_d_ready)));
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("stall_rst", 32'(stall), 32'h0);
    rst_n = 1'b1;

    // Single fetch, immediate ack.
    mode = 3; force_lat = 0; fix_rd = 1; fix_rdata = 32'h8C01_0004;
    if_req = 1; if_addr = 32'h40;
    repeat (5) cycle();

    // Store with three wait cycles.
    d_req = 1; d_wr = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; force_lat = 3;
    repeat (8) cycle();

    // Load that never acks, fetch waiting behind it.
    d_req = 1; d_wr = 0; d_addr = 32'h200; force_lat = 100;
    repeat (2) cycle();
    force_lat = 0; if_req = 1; if_addr = 32'h44;
    repeat (10) cycle();

    // Ack in the expiry cycle.
    fix_rdata = 32'h1234_5678; force_lat = 4;
    d_req = 1; d_wr = 0; d_addr = 32'h300;
    repeat (9) cycle();

    // Reset in the middle of a fetch.
    force_lat = 100; if_req = 1; if_addr = 32'h80;
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_if_ready", 32'(if_ready), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    model_reset();
    force_lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cycle();

    // Continuous contention and fetch starvation, immediate acks.
    fix_rd = 0; force_lat = 0;
    mode = 2; repeat (30) cycle();
    mode = 1; repeat (60) cycle();

    // Randomized traffic with random latencies, collisions and timeouts.
    force_lat = -1; mode = 0;
    repeat (3000) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
